// File: rtl/proc_pkg.sv
// Shared definitions for the fetch path: FSM encoding, PC stepping and the
// instruction immediate field used to build jump targets.
package proc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    localparam int          ADDR_W   = 16;
    localparam int          REGION_W = 2;
    localparam int          PC_STEP  = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;

    localparam int IMM_HI = 12;
    localparam int IMM_LO = 0;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: sequential increment, region-preserving jump target
// and the mux between them.
module pc_next_sel
    import proc_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int REGION_W = 2,
    parameter int PC_STEP  = 2
) (
    input  logic [ADDR_W-1:0]      pc,
    input  logic [ADDR_W-1:0]      pc_inc,
    input  logic [IMM_HI-IMM_LO:0] imm,
    input  logic                   jump_taken,
    output logic [ADDR_W-1:0]      pc_inc_next,
    output logic [ADDR_W-1:0]      jump_target,
    output logic [ADDR_W-1:0]      pc_sel
);

    assign pc_inc_next = pc + ADDR_W'(PC_STEP);

    // Region bits come from the incremented PC so a jump in a region's last
    // word lands in the following region.
    assign jump_target = {pc_inc[ADDR_W-1 -: REGION_W], imm, 1'b0};

    assign pc_sel = jump_taken ? jump_target : pc_inc;

endmodule

// File: rtl/pc_jump_fetch_unit.sv
// Program counter owner and instruction fetch handshake: fetches one word,
// holds it in IR until the control unit retires it, then steps or jumps.
module pc_jump_fetch_unit #(
    parameter int          ADDR_W   = proc_pkg::ADDR_W,
    parameter int          REGION_W = proc_pkg::REGION_W,
    parameter int          PC_STEP  = proc_pkg::PC_STEP,
    parameter logic [15:0] RESET_PC = proc_pkg::RESET_PC
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              FetchEn,
    input  logic              Advance,
    input  logic              JumpTaken,
    input  logic              MemReady,
    input  logic [15:0]       MemData,
    output logic              MemRead,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [ADDR_W-1:0] PC,
    output logic [15:0]       IR,
    output logic              InstrValid,
    output logic [ADDR_W-1:0] JumpTarget
);
    import proc_pkg::*;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_inc_q, pc_inc_d;
    logic [15:0]       ir_q, ir_d;
    logic              valid_q, valid_d;
    logic              mem_read_q, mem_read_d;

    logic [ADDR_W-1:0] pc_inc_next;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] pc_sel;

    pc_next_sel #(
        .ADDR_W   (ADDR_W),
        .REGION_W (REGION_W),
        .PC_STEP  (PC_STEP)
    ) u_pc_next_sel (
        .pc          (pc_q),
        .pc_inc      (pc_inc_q),
        .imm         (ir_q[IMM_HI:IMM_LO]),
        .jump_taken  (JumpTaken),
        .pc_inc_next (pc_inc_next),
        .jump_target (jump_target),
        .pc_sel      (pc_sel)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_inc_d   = pc_inc_q;
        ir_d       = ir_q;
        valid_d    = valid_q;
        mem_read_d = mem_read_q;
        case (state_q)
            IDLE: begin
                if (FetchEn) begin
                    state_d    = FETCH;
                    mem_read_d = 1'b1;
                end
            end
            FETCH: begin
                // FetchEn is deliberately ignored here: a started fetch completes.
                if (MemReady) begin
                    ir_d       = MemData;
                    pc_inc_d   = pc_inc_next;
                    valid_d    = 1'b1;
                    mem_read_d = 1'b0;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (Advance) begin
                    valid_d = 1'b0;
                    pc_d    = pc_sel;
                    if (FetchEn) begin
                        state_d    = FETCH;
                        mem_read_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                mem_read_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= IDLE;
            pc_q       <= ADDR_W'(RESET_PC);
            pc_inc_q   <= '0;
            ir_q       <= '0;
            valid_q    <= 1'b0;
            mem_read_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_inc_q   <= pc_inc_d;
            ir_q       <= ir_d;
            valid_q    <= valid_d;
            mem_read_q <= mem_read_d;
        end
    end

    assign MemRead    = mem_read_q;
    assign MemAddr    = pc_q;
    assign PC         = pc_q;
    assign IR         = ir_q;
    assign InstrValid = valid_q;
    assign JumpTarget = jump_target;

endmodule

// File: tb/tb_pc_jump_fetch_unit.sv
// Directed bench: three instances with different reset PCs share one stimulus
// stream; each phase checks the instance whose reset PC suits the scenario.
module tb_pc_jump_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, fetch_en, advance, jump_taken, mem_ready;
    logic [15:0] mem_data;

    logic        mem_read   [3];
    logic [15:0] mem_addr   [3];
    logic [15:0] pc         [3];
    logic [15:0] ir         [3];
    logic        iv         [3];
    logic [15:0] jt         [3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pc_jump_fetch_unit #(
            .RESET_PC (g == 0 ? 16'h0000 : (g == 1 ? 16'h4006 : 16'hFFFE))
        ) u_dut (
            .CLK        (clk),
            .Reset      (reset),
            .FetchEn    (fetch_en),
            .Advance    (advance),
            .JumpTaken  (jump_taken),
            .MemReady   (mem_ready),
            .MemData    (mem_data),
            .MemRead    (mem_read[g]),
            .MemAddr    (mem_addr[g]),
            .PC         (pc[g]),
            .IR         (ir[g]),
            .InstrValid (iv[g]),
            .JumpTarget (jt[g])
        );
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        fetch_en   = 1'b0;
        advance    = 1'b0;
        jump_taken = 1'b0;
        mem_ready  = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // IDLE -> FETCH (one cycle with MemRead high) -> HOLD with word d.
    task automatic fetch(input logic [15:0] d);
        fetch_en = 1'b1;
        tick();
        mem_data  = d;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
    endtask

    initial begin
        mem_data = 16'h0000;
        do_reset();
        chk("rst_pc", pc[0], 16'h0000);
        chk("rst_ir", ir[0], 16'h0000);
        chk("rst_iv", iv[0], 1'b0);
        chk("rst_mr", mem_read[0], 1'b0);
        chk("rst_jt", jt[0], 16'h0000);
        chk("rst_pc_ffe", pc[2], 16'hFFFE);

        // Basic fetch with MemReady one cycle after MemRead
        fetch_en = 1'b1;
        tick();
        chk("f1_mr", mem_read[0], 1'b1);
        chk("f1_addr", mem_addr[0], 16'h0000);
        mem_data  = 16'h1234;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("f1_ir", ir[0], 16'h1234);
        chk("f1_iv", iv[0], 1'b1);
        chk("f1_pc", pc[0], 16'h0000);
        chk("f1_mr_off", mem_read[0], 1'b0);

        // JumpTaken alone does nothing
        jump_taken = 1'b1;
        tick();
        jump_taken = 1'b0;
        chk("jt_noadv_pc", pc[0], 16'h0000);
        chk("jt_noadv_iv", iv[0], 1'b1);

        // Sequential advance
        advance = 1'b1;
        tick();
        advance = 1'b0;
        chk("adv_pc", pc[0], 16'h0002);
        chk("adv_iv", iv[0], 1'b0);
        chk("adv_mr", mem_read[0], 1'b1);
        chk("adv_addr", mem_addr[0], 16'h0002);

        // Slow memory: request held with stable address
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("slow_mr", mem_read[0], 1'b1);
            chk("slow_addr", mem_addr[0], 16'h0002);
        end
        mem_data  = 16'h2000;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("slow_ir", ir[0], 16'h2000);
        chk("slow_iv", iv[0], 1'b1);

        // Advance with FetchEn low parks in IDLE
        fetch_en = 1'b0;
        advance  = 1'b1;
        tick();
        advance = 1'b0;
        chk("idle_pc", pc[0], 16'h0004);
        chk("idle_mr", mem_read[0], 1'b0);
        tick();
        chk("idle_mr2", mem_read[0], 1'b0);
        advance    = 1'b1;
        jump_taken = 1'b1;
        tick();
        advance    = 1'b0;
        jump_taken = 1'b0;
        chk("idle_adv_pc", pc[0], 16'h0004);
        chk("idle_adv_mr", mem_read[0], 1'b0);

        // Reset during FETCH with MemReady in that and the next cycle
        fetch_en = 1'b1;
        tick();
        chk("r5_mr", mem_read[0], 1'b1);
        chk("r5_addr", mem_addr[0], 16'h0004);
        mem_data  = 16'hBEEF;
        mem_ready = 1'b1;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        chk("r5_ir", ir[0], 16'h0000);
        chk("r5_iv", iv[0], 1'b0);
        chk("r5_mr0", mem_read[0], 1'b0);
        chk("r5_pc", pc[0], 16'h0000);
        tick();
        chk("r5_ir_after", ir[0], 16'h0000);
        chk("r5_iv_after", iv[0], 1'b0);
        chk("r5_mr_after", mem_read[0], 1'b1);
        tick();
        mem_ready = 1'b0;
        chk("r5_first_cycle_ir", ir[0], 16'hBEEF);
        chk("r5_first_cycle_iv", iv[0], 1'b1);

        // Jump from 4006 with IR=0ABC
        do_reset();
        fetch(16'h0ABC);
        chk("j3_pc", pc[1], 16'h4006);
        chk("j3_ir", ir[1], 16'h0ABC);
        chk("j3_jt", jt[1], 16'h5578);
        chk("j3_jt_wrap", jt[2], 16'h1578);
        advance    = 1'b1;
        jump_taken = 1'b1;
        tick();
        advance    = 1'b0;
        jump_taken = 1'b0;
        chk("j3_pc_new", pc[1], 16'h5578);
        chk("j3_addr_new", mem_addr[1], 16'h5578);
        chk("j3_pc_zero_dut", pc[0], 16'h1578);

        // Wrap at FFFE: jump and non-jump
        do_reset();
        fetch(16'h0001);
        chk("w4_pc", pc[2], 16'hFFFE);
        chk("w4_jt", jt[2], 16'h0002);
        advance    = 1'b1;
        jump_taken = 1'b1;
        tick();
        advance    = 1'b0;
        jump_taken = 1'b0;
        chk("w4_jump_pc", pc[2], 16'h0002);
        do_reset();
        fetch(16'h0001);
        advance = 1'b1;
        tick();
        advance = 1'b0;
        chk("w4_seq_pc", pc[2], 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
